// File: rtl/config_frame_sequencer_if.sv
// rtl/config_frame_sequencer_if.sv - word stream handshake into the frame sequencer
interface config_frame_sequencer_if;
    logic [31:0] s_data;
    logic        s_valid;
    logic        s_ready;

    modport master (output s_data, output s_valid, input s_ready);
    modport slave  (input s_data, input s_valid, output s_ready);
endinterface

// File: rtl/config_frame_sequencer.sv
// rtl/config_frame_sequencer.sv - assembles header+row words into a frame and strobes it into one column frame slot
module config_frame_sequencer #(
    parameter int          FrameBitsPerRow = 32,
    parameter int          MaxFramesPerCol = 20,
    parameter int          NumberOfRows    = 4,
    parameter int          NumberOfCols    = 4,
    parameter logic [7:0]  SyncByte        = 8'hFA
) (
    input  logic                                      CLK,
    input  logic                                      resetn,
    config_frame_sequencer_if.slave                   s,
    output logic [FrameBitsPerRow*NumberOfRows-1:0]   FrameData,
    output logic [MaxFramesPerCol*NumberOfCols-1:0]   FrameStrobe,
    output logic                                      busy,
    output logic                                      err,
    input  logic                                      err_clr,
    output logic [15:0]                               frame_count
);
    localparam int FDW = FrameBitsPerRow * NumberOfRows;
    localparam int SW  = MaxFramesPerCol * NumberOfCols;
    localparam int IW  = $clog2(SW);
    localparam int RW  = (NumberOfRows > 1) ? $clog2(NumberOfRows) : 1;
    localparam int CW  = (NumberOfCols > 1) ? $clog2(NumberOfCols) : 1;

    typedef enum logic [1:0] {IDLE, LOAD, STROBE, HOLD} state_e;

    state_e          state_q, state_d;
    logic [FDW-1:0]  frame_data_q, frame_data_d;
    logic [SW-1:0]   strobe_q, strobe_d;
    logic            s_ready_q, s_ready_d;
    logic            err_q, err_d;
    logic [15:0]     count_q, count_d;
    logic [RW-1:0]   row_q, row_d;
    logic [CW-1:0]   col_q, col_d;
    logic [4:0]      frame_q, frame_d;
    logic            xfer, hdr_ok, last_row;
    logic [IW-1:0]   strobe_idx;

    assign xfer       = s.s_valid && s_ready_q;
    assign hdr_ok     = (s.s_data[31:24] == SyncByte)
                     && (s.s_data[15:8] < 8'(NumberOfCols))
                     && (s.s_data[4:0] < 5'(MaxFramesPerCol));
    assign last_row   = (row_q == RW'(NumberOfRows - 1));
    assign strobe_idx = IW'(col_q) * IW'(MaxFramesPerCol) + IW'(frame_q);

    always_ff @(posedge CLK) begin
        if (!resetn) begin
            state_q      <= IDLE;
            frame_data_q <= '0;
            strobe_q     <= '0;
            s_ready_q    <= 1'b0;
            err_q        <= 1'b0;
            count_q      <= '0;
            row_q        <= '0;
            col_q        <= '0;
            frame_q      <= '0;
        end else begin
            state_q      <= state_d;
            frame_data_q <= frame_data_d;
            strobe_q     <= strobe_d;
            s_ready_q    <= s_ready_d;
            err_q        <= err_d;
            count_q      <= count_d;
            row_q        <= row_d;
            col_q        <= col_d;
            frame_q      <= frame_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (xfer && hdr_ok) state_d = LOAD;
            LOAD:    if (xfer && last_row) state_d = STROBE;
            STROBE:  state_d = HOLD;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        frame_data_d = frame_data_q;
        row_d        = row_q;
        col_d        = col_q;
        frame_d      = frame_q;
        count_d      = count_q;
        strobe_d     = '0;
        s_ready_d    = (state_d == IDLE) || (state_d == LOAD);

        // A new invalid header must win over a simultaneous clear request.
        err_d = err_clr ? 1'b0 : err_q;
        if (state_q == IDLE && xfer) begin
            if (hdr_ok) begin
                col_d   = s.s_data[8 +: CW];
                frame_d = s.s_data[4:0];
                row_d   = '0;
            end else begin
                err_d = 1'b1;
            end
        end

        if (state_q == LOAD && xfer) begin
            for (int r = 0; r < NumberOfRows; r++) begin
                if (row_q == RW'(r)) frame_data_d[r*FrameBitsPerRow +: FrameBitsPerRow] = s.s_data;
            end
            row_d = last_row ? '0 : row_q + RW'(1);
        end

        if (state_d == STROBE) begin
            for (int i = 0; i < SW; i++) strobe_d[i] = (strobe_idx == IW'(i));
        end

        if (state_q == STROBE) count_d = count_q + 16'd1;
    end

    assign s.s_ready   = s_ready_q;
    assign FrameData   = frame_data_q;
    assign FrameStrobe = strobe_q;
    assign busy        = (state_q != IDLE);
    assign err         = err_q;
    assign frame_count = count_q;
endmodule

// File: tb/tb_config_frame_sequencer.sv
// tb/tb_config_frame_sequencer.sv - directed and randomized frames checked against a row-array reference model
module tb_config_frame_sequencer;
    localparam int NR = 4;
    localparam int MF = 20;
    localparam int NC = 4;

    logic          CLK = 1'b0;
    logic          resetn = 1'b0;
    logic          err_clr = 1'b0;
    logic [127:0]  FrameData;
    logic [79:0]   FrameStrobe;
    logic          busy, err;
    logic [15:0]   frame_count;

    config_frame_sequencer_if sif();

    config_frame_sequencer dut (
        .CLK         (CLK),
        .resetn      (resetn),
        .s           (sif.slave),
        .FrameData   (FrameData),
        .FrameStrobe (FrameStrobe),
        .busy        (busy),
        .err         (err),
        .err_clr     (err_clr),
        .frame_count (frame_count)
    );

    always #5 CLK = ~CLK;

    int compared = 0;
    int mismatched = 0;
    int strobe_pulses = 0;
    int m_frames = 0;
    logic [31:0] m_rows [NR];
    logic [31:0] m_next [NR];
    logic [15:0] m_count = 16'd0;
    logic        m_err = 1'b0;

    always @(negedge CLK) if (FrameStrobe != 80'd0) strobe_pulses++;

    function automatic logic [127:0] model_data();
        logic [127:0] v;
        for (int r = 0; r < NR; r++) v[r*32 +: 32] = m_rows[r];
        return v;
    endfunction

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        @(negedge CLK);
    endtask

    // Called at a negedge; returns at the negedge following the accepting edge.
    task automatic send(input logic [31:0] w);
        bit ok, rdy;
        ok = 0;
        sif.s_data = w;
        sif.s_valid = 1'b1;
        for (int t = 0; t < 50; t++) begin
            rdy = sif.s_ready;
            @(posedge CLK);
            if (rdy) begin
                ok = 1;
                break;
            end
            @(negedge CLK);
        end
        @(negedge CLK);
        sif.s_valid = 1'b0;
        if (!ok) check("send_timeout", 128'd0, 128'd1);
    endtask

    task automatic model_reset();
        for (int r = 0; r < NR; r++) m_rows[r] = 32'd0;
        m_count = 16'd0;
        m_err = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_data"}, FrameData, 128'd0);
        check({tag, "_strobe"}, {48'd0, FrameStrobe}, 128'd0);
        check({tag, "_ready"}, {127'd0, sif.s_ready}, 128'd0);
        check({tag, "_busy"}, {127'd0, busy}, 128'd0);
        check({tag, "_err"}, {127'd0, err}, 128'd0);
        check({tag, "_count"}, {112'd0, frame_count}, 128'd0);
    endtask

    // Sends a header, then (if the header is legal) the rows in m_next with 'gap' idle cycles between words.
    task automatic do_frame(input logic [31:0] hdr, input int gap);
        bit valid;
        int col, fr;
        logic [79:0] one, exp_strobe;
        valid = (hdr[31:24] == 8'hFA) && (hdr[15:8] < 8'(NC)) && (hdr[4:0] < 5'(MF));
        col = int'(hdr[15:8]);
        fr = int'(hdr[4:0]);
        send(hdr);
        if (!valid) begin
            m_err = 1'b1;
            check("bad_hdr_err", {127'd0, err}, {127'd0, m_err});
            check("bad_hdr_busy", {127'd0, busy}, 128'd0);
            check("bad_hdr_strobe", {48'd0, FrameStrobe}, 128'd0);
            check("bad_hdr_data", FrameData, model_data());
            return;
        end
        check("hdr_busy", {127'd0, busy}, 128'd1);
        for (int r = 0; r < NR; r++) begin
            repeat (gap) begin
                step();
                check("gap_strobe", {48'd0, FrameStrobe}, 128'd0);
                check("gap_ready", {127'd0, sif.s_ready}, 128'd1);
            end
            send(m_next[r]);
            m_rows[r] = m_next[r];
            if (r < NR - 1) begin
                check("load_strobe", {48'd0, FrameStrobe}, 128'd0);
                check("load_ready", {127'd0, sif.s_ready}, 128'd1);
            end
        end
        one = 80'd1;
        exp_strobe = one << (col * MF + fr);
        check("strobe_onehot", {48'd0, FrameStrobe}, {48'd0, exp_strobe});
        check("strobe_data", FrameData, model_data());
        check("strobe_ready", {127'd0, sif.s_ready}, 128'd0);
        step();
        m_count = m_count + 16'd1;
        m_frames++;
        check("hold_strobe", {48'd0, FrameStrobe}, 128'd0);
        check("hold_ready", {127'd0, sif.s_ready}, 128'd0);
        check("hold_data", FrameData, model_data());
        check("hold_count", {112'd0, frame_count}, {112'd0, m_count});
        step();
        check("idle_busy", {127'd0, busy}, 128'd0);
        check("idle_ready", {127'd0, sif.s_ready}, 128'd1);
    endtask

    task automatic clear_err();
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        m_err = 1'b0;
        check("err_clr", {127'd0, err}, {127'd0, m_err});
    endtask

    initial begin
        logic [31:0] bad_hdrs [3];
        logic [31:0] hdr;
        int kind;
        int pulses_before;
        bad_hdrs[0] = 32'hFB00_0000;
        bad_hdrs[1] = 32'hFA00_0400;
        bad_hdrs[2] = 32'hFA00_0014;
        sif.s_data = 32'd0;
        sif.s_valid = 1'b0;
        model_reset();

        repeat (2) @(posedge CLK);
        @(negedge CLK);
        check_reset_outputs("reset");
        resetn = 1'b1;
        step();
        check("first_ready", {127'd0, sif.s_ready}, 128'd1);

        m_next[0] = 32'h11111111; m_next[1] = 32'h22222222;
        m_next[2] = 32'h33333333; m_next[3] = 32'h44444444;
        do_frame(32'hFA00_0103, 0);
        check("basic_data_const", FrameData, 128'h44444444_33333333_22222222_11111111);
        check("basic_count", {112'd0, frame_count}, 128'd1);
        do_frame(32'hFA00_0103, 3);

        for (int i = 0; i < 3; i++) begin
            do_frame(bad_hdrs[i], 0);
            clear_err();
        end
        do_frame(32'hFB12_3456, 0);
        err_clr = 1'b1;
        do_frame(32'hFA00_0500, 0);
        err_clr = 1'b0;
        clear_err();

        for (int r = 0; r < NR; r++) m_next[r] = $urandom;
        do_frame(32'hFA00_0313, 0);
        for (int r = 0; r < NR; r++) m_next[r] = $urandom;
        do_frame(32'hFA00_0000, 1);

        pulses_before = strobe_pulses;
        send(32'hFA00_0205);
        send(32'hAAAA5555);
        send(32'h5555AAAA);
        resetn = 1'b0;
        step();
        model_reset();
        check_reset_outputs("midload");
        step();
        resetn = 1'b1;
        step();
        check("midload_ready", {127'd0, sif.s_ready}, 128'd1);
        check("midload_nostrobe", 128'(strobe_pulses), 128'(pulses_before));
        for (int r = 0; r < NR; r++) m_next[r] = $urandom;
        do_frame(32'hFA00_020B, 0);

        for (int n = 0; n < 30; n++) begin
            for (int r = 0; r < NR; r++) m_next[r] = $urandom;
            hdr = $urandom;
            kind = int'($urandom_range(0, 5));
            hdr[31:24] = 8'hFA;
            hdr[15:8] = 8'($urandom_range(0, NC - 1));
            hdr[4:0] = 5'($urandom_range(0, MF - 1));
            if (kind == 0) hdr[31:24] = 8'hFA ^ 8'($urandom_range(1, 255));
            if (kind == 1) hdr[15:8] = 8'($urandom_range(NC, 255));
            if (kind == 2) hdr[4:0] = 5'($urandom_range(MF, 31));
            do_frame(hdr, int'($urandom_range(0, 2)));
            if (m_err) clear_err();
        end

        force dut.count_q = 16'hFFFF;
        step();
        release dut.count_q;
        m_count = 16'hFFFF;
        step();
        check("wrap_preload", {112'd0, frame_count}, {112'd0, m_count});
        for (int r = 0; r < NR; r++) m_next[r] = $urandom;
        do_frame(32'hFA00_0107, 0);
        check("wrap_zero", {112'd0, frame_count}, 128'd0);

        step();
        check("total_strobes", 128'(strobe_pulses), 128'(m_frames));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule

// File: doc/config_frame_sequencer.md
Name: config_frame_sequencer

Overview:
- Drives the frame-write interface of the fabric configuration memories. It is the writer that feeds every tile ConfigMem's FrameData/FrameStrobe inputs.
- Accepts a 32-bit word stream (header plus one data word per row) over a valid/ready handshake.
- Assembles one full frame across all rows, then issues a single-cycle one-hot strobe to the addressed frame of the addressed column.
- Sits between the bitstream loader (UART/SPI/parallel) and the fabric frame distribution network.

Parameters:
- FrameBitsPerRow, 32, data bits per row per frame; must be 32.
- MaxFramesPerCol, 20, frames per column; strobe lines per column.
- NumberOfRows, 4, tile rows receiving frame data.
- NumberOfCols, 4, tile columns; one strobe group each.
- SyncByte, 8'hFA, required header bits [31:24].

Ports:
- CLK  input  1  clock; all logic on rising edge.
- resetn  input  1  synchronous active-low reset.
- s_data  input  32  stream word.
- s_valid  input  1  s_data is valid.
- s_ready  output  1  sequencer accepts s_data this cycle.
- FrameData  output  FrameBitsPerRow*NumberOfRows  row r occupies bits [32r+31:32r].
- FrameStrobe  output  MaxFramesPerCol*NumberOfCols  one-hot; bit col*MaxFramesPerCol+frame.
- busy  output  1  high whenever state is not IDLE.
- err  output  1  sticky header error.
- err_clr  input  1  clears err.
- frame_count  output  16  number of strobes issued; wraps 16'hFFFF to 0.

Behaviour:
- Reset (resetn=0 at CLK edge): state IDLE, FrameData=0, FrameStrobe=0, s_ready=0, busy=0, err=0, frame_count=0, row counter=0. Reset mid-operation discards the partial frame and issues no strobe.
- Transfer rule: a word is accepted only when s_valid and s_ready are both high at the edge. s_ready is a registered function of state: high in IDLE and LOAD, low in STROBE and HOLD. On the first cycle after reset release s_ready=1.
- IDLE: the accepted word is a header. It is valid iff all of the following hold:
  - [31:24]==SyncByte
  - [15:8] < NumberOfCols
  - [4:0] < MaxFramesPerCol
  - If valid: latch col and frame, clear the row counter, go to LOAD.
  - If invalid: set err, stay IDLE, leave FrameData unchanged.
- LOAD: each accepted word is written to the FrameData slot at the row counter, and the row counter increments. When the word for row NumberOfRows-1 is accepted, go to STROBE. s_valid gaps stall LOAD indefinitely with no timeout. FrameData slots update as written; the other slots hold their previous values.
- STROBE (1 cycle): FrameStrobe has exactly one bit high, at index col*MaxFramesPerCol+frame. frame_count increments at the end of this cycle. FrameData is stable. Next state is HOLD.
- HOLD (1 cycle): FrameStrobe=0 and FrameData still stable (hold margin for the latches). Next state is IDLE.
- FrameStrobe is registered and is 0 in every state except STROBE. FrameData is never cleared except by reset.
- Throughput: header plus NumberOfRows words plus 2 cycles per frame. A minimum frame with continuous s_valid takes NumberOfRows+3 cycles, header edge to the next IDLE.
- Latency: the strobe rises on the cycle after the last data word is accepted.
- err: set on an invalid header, cleared when err_clr=1. If set and clear occur in the same cycle, set wins.
- busy = (state != IDLE).

Test Plan:
- Basic frame, defaults: header 32'hFA00_0103 then data words 11111111, 22222222, 33333333, 44444444 with continuous valid.
  - Expected: FrameData = 44444444_33333333_22222222_11111111.
  - FrameStrobe bit 23 (1*20+3) high for exactly 1 cycle, on the cycle after word 4 is accepted.
  - s_ready low for 2 cycles, frame_count=1.
- Backpressure/gaps: same frame with s_valid dropped for 3 cycles between each word.
  - Expected: identical FrameData/strobe result.
  - No strobe until the 4th word; s_ready stays 1 throughout LOAD.
- Bad headers:
  - 32'hFB00_0000 (bad sync), 32'hFA00_0400 (col 4), 32'hFA00_0014 (frame 20), each sent individually.
  - Expected for each: err=1, state stays IDLE, no strobe, FrameData unchanged.
  - Then err_clr=1 → err=0.
  - Next, a valid header is accepted.
- Corner addressing: header 32'hFA00_0313 (col 3, frame 19).
  - Expected: strobe bit 79 only.
  - Then header 32'hFA00_0000: strobe bit 0 only.
- Reset mid-LOAD: resetn=0 after 2 data words.
  - Expected: all outputs return to reset values on the next edge, and no strobe is ever issued.
  - A subsequent full frame works normally.
- Counter wrap: force/preload frame_count=16'hFFFF, then run one frame.
  - Expected: frame_count=0 after STROBE.
